fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have a parameter ADDR_W, default 9: instruction memory address width.
REQ-002 The block SHALL have a parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk  input  1  sole clock, rising edge.
REQ-005 Port reset  input  1  synchronous active-high reset.
REQ-006 Port start  input  1  begin fetching from current PC; sampled in IDLE only.
REQ-007 Port stop  input  1  return to IDLE after the current instruction retires.
REQ-008 Port mem_addr  output  ADDR_W  instruction read address; equals pc.
REQ-009 Port mem_rd  output  1  read request, high throughout FETCH.
REQ-010 Port mem_rdata  input  16  instruction word from memory.
REQ-011 Port mem_ready  input  1  read data valid this cycle; ignored outside FETCH.
REQ-012 Port instr  output  16  registered instruction presented to the CPU instruction input.
REQ-013 Port cpu_load  output  1  CPU instruction-register load strobe.
REQ-014 Port cpu_s  output  1  CPU start strobe.
REQ-015 Port cpu_w  input  1  CPU wait flag; high when the CPU is idle and ready.
REQ-016 Port pc  output  ADDR_W  program counter.
REQ-017 Port retired  output  16  count of retired instructions, wraps modulo 2^16.
REQ-018 Port busy  output  1  high in every state except IDLE and HALT.
REQ-019 Port halted  output  1  high in HALT; constant 0 when the halt feature is compiled out.

Function
REQ-020 States SHALL be IDLE, FETCH, LOAD, START, SETTLE, EXEC, INCR, HALT.
REQ-021 IDLE: start=1 and stop=0 -> FETCH; start and stop both high -> stay IDLE; otherwise stay.
REQ-022 FETCH: mem_rd=1, mem_addr=pc; on mem_ready=1, instr<=mem_rdata -> LOAD; else stay (unbounded wait).
REQ-023 LOAD: cpu_load=1 for exactly one cycle with instr stable -> START.
REQ-024 START: cpu_s=1 for exactly one cycle -> SETTLE.
REQ-025 SETTLE: one cycle; cpu_w is ignored -> EXEC.
REQ-026 EXEC: stay while cpu_w=0; cpu_w=1 -> INCR.
REQ-027 INCR: pc<=pc+1 modulo 2^ADDR_W (all-ones wraps to 0), retired<=retired+1; stop=1 -> IDLE, else FETCH.
REQ-028 stop SHALL be sampled only in INCR and IDLE; a stop pulse in any other state is lost.
REQ-029 start outside IDLE SHALL be ignored.
REQ-030 cpu_load, cpu_s, mem_rd SHALL be registered, glitch-free, and mutually exclusive.
REQ-031 Minimum per-instruction latency with mem_ready=1 and cpu_w returning in EXEC's first cycle: FETCH to FETCH = 6 cycles.
REQ-032 instr SHALL change only on the FETCH-to-LOAD transition.

Reset
REQ-033 reset SHALL force state=IDLE, pc=RESET_PC, instr=0, retired=0, and mem_rd=cpu_load=cpu_s=busy=halted=0 at the next rising edge, from any state.
REQ-034 reset SHALL take priority over start, stop, mem_ready and cpu_w.

Configuration
REQ-035 Macro FETCH_SEQUENCER_HALT_EN defined: in LOAD, if instr[15:13]==3'b111, the block SHALL go to HALT without asserting cpu_load or cpu_s; HALT holds pc, sets halted=1, and exits only on reset.
REQ-036 Macro undefined: no HALT state; opcode 3'b111 is sequenced like any other instruction; halted is tied 0.

Verification
REQ-037 Reset then start=1 one cycle, mem_ready=1, rdata=16'hD105, cpu_w high 1 cycle after SETTLE -> cpu_load then cpu_s single pulses, pc 0->1, retired=1, next FETCH at addr 1.
REQ-038 mem_ready held low 5 cycles in FETCH -> mem_rd high 5+1 cycles, mem_addr stable, no cpu_load until ready.
REQ-039 pc=2^ADDR_W-1 (511), instruction retires -> pc=0.
REQ-040 stop pulsed during EXEC -> ignored, continues; stop high in INCR -> IDLE, busy=0, pc incremented.
REQ-041 reset asserted in EXEC with cpu_w=0 -> next cycle IDLE, pc=RESET_PC, retired=0, all strobes 0.
REQ-042 With FETCH_SEQUENCER_HALT_EN, rdata=16'hE000 -> HALT, halted=1, no cpu_s, pc unchanged; without the macro -> normal cpu_load and cpu_s pulses.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches a word per PC, hands it to the CPU, waits for completion.
// Optional HALT opcode (3'b111) support is enabled by defining FETCH_SEQUENCER_HALT_EN.
module fetch_sequencer #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [15:0]       instr,
  output logic              cpu_load,
  output logic              cpu_s,
  input  logic              cpu_w,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       retired,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StStart,
    StSettle,
    StExec,
    StIncr
`ifdef FETCH_SEQUENCER_HALT_EN
    , StHalt
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       retired_q, retired_d;
  logic              mem_rd_q, mem_rd_d;
  logic              cpu_load_q, cpu_load_d;
  logic              cpu_s_q, cpu_s_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= ADDR_W'(RESET_PC);
      instr_q    <= 16'h0000;
      retired_q  <= 16'h0000;
      mem_rd_q   <= 1'b0;
      cpu_load_q <= 1'b0;
      cpu_s_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      retired_q  <= retired_d;
      mem_rd_q   <= mem_rd_d;
      cpu_load_q <= cpu_load_d;
      cpu_s_q    <= cpu_s_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      StIdle: begin
        if (start && !stop) state_d = StFetch;
      end
      StFetch: begin
        if (mem_ready) begin
          instr_d = mem_rdata;
          state_d = StLoad;
        end
      end
      StLoad: begin
`ifdef FETCH_SEQUENCER_HALT_EN
        if (instr_q[15:13] == 3'b111) state_d = StHalt;
        else                          state_d = StStart;
`else
        state_d = StStart;
`endif
      end
      StStart:  state_d = StSettle;
      // CPU's wait flag is not yet valid the cycle after the start strobe.
      StSettle: state_d = StExec;
      StExec: begin
        if (cpu_w) state_d = StIncr;
      end
      StIncr: begin
        pc_d      = pc_q + ADDR_W'(1);
        retired_d = retired_q + 16'd1;
        state_d   = stop ? StIdle : StFetch;
      end
`ifdef FETCH_SEQUENCER_HALT_EN
      StHalt: state_d = StHalt;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Strobes are decoded from the next state so they come straight out of flops.
  always_comb begin
    mem_rd_d   = (state_d == StFetch);
    cpu_s_d    = (state_d == StStart);
    cpu_load_d = (state_d == StLoad);
`ifdef FETCH_SEQUENCER_HALT_EN
    if (instr_d[15:13] == 3'b111) cpu_load_d = 1'b0;
`endif
    busy   = (state_q != StIdle);
    halted = 1'b0;
`ifdef FETCH_SEQUENCER_HALT_EN
    if (state_q == StHalt) begin
      busy   = 1'b0;
      halted = 1'b1;
    end
`endif
  end

  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign instr    = instr_q;
  assign retired  = retired_q;
  assign mem_rd   = mem_rd_q;
  assign cpu_load = cpu_load_q;
  assign cpu_s    = cpu_s_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: random memory/CPU timing against a transaction-level model.
// Also covers the FETCH_SEQUENCER_HALT_EN build when that macro is defined.
module tb_fetch_sequencer;

  localparam int unsigned AW    = 9;
  localparam int unsigned RPC   = 510;
  localparam int unsigned DEPTH = 512;

  logic          clk = 1'b0;
  logic          reset, start, stop;
  logic [AW-1:0] mem_addr, pc;
  logic          mem_rd, mem_ready, cpu_load, cpu_s, cpu_w, busy, halted;
  logic [15:0]   mem_rdata, instr, retired;

  fetch_sequencer #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .instr     (instr),
    .cpu_load  (cpu_load),
    .cpu_s     (cpu_s),
    .cpu_w     (cpu_w),
    .pc        (pc),
    .retired   (retired),
    .busy      (busy),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   word;
    logic [15:0]   ret;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] mem [DEPTH];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          fixed_stall = -1;
  int          fixed_delay = -1;
  int          pc_m;
  logic [15:0] ret_m;
  int          last_gap, last_rd_len, rd_len;
  bit          addr_moved;
  logic [AW-1:0] rd_addr;
  bit          rst_at_edge = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_at_edge = reset;
  end

  // Memory: random stall per fetch (or a fixed one), random ready noise outside FETCH.
  int mem_age = 0;
  int cur_stall = 0;
  always begin
    @(posedge clk);
    #1;
    if (mem_rd) begin
      if (mem_age == 0) cur_stall = (fixed_stall >= 0) ? fixed_stall : int'($urandom_range(0, 3));
      mem_ready = (mem_age >= cur_stall);
      mem_rdata = mem_ready ? mem[mem_addr] : 16'($urandom);
      mem_age++;
    end else begin
      mem_age   = 0;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
    end
  end

  // CPU: drops the wait flag after a start strobe, raises it again after a delay.
  int cpu_cnt = 0;
  always begin
    @(posedge clk);
    #1;
    if (cpu_s) begin
      cpu_w   = 1'b0;
      cpu_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
    end else if (!cpu_w) begin
      if (cpu_cnt == 0) cpu_w = 1'b1;
      else cpu_cnt--;
    end
  end

  // Monitor: every load strobe must match the next expected instruction.
  logic [15:0] prev_instr = 16'h0;
  logic        prev_mem_rd = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      check("strobe_onehot0", 32'($onehot0({mem_rd, cpu_load, cpu_s})), 32'd1);
      if (instr != prev_instr && !rst_at_edge)
        check("instr_changes_only_leaving_fetch", 32'(prev_mem_rd && !mem_rd), 32'd1);
      if (cpu_load) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_load: got instr %h at pc %0d, expected no load", instr, pc);
        end else begin
          e = sb_q.pop_front();
          check("load_instr", 32'(instr), 32'(e.word));
          check("load_pc", 32'(pc), 32'(e.addr));
          check("load_retired", 32'(retired), 32'(e.ret));
        end
      end
    end
    prev_instr  = instr;
    prev_mem_rd = mem_rd;
  end

  // Run n instructions from IDLE; stop is raised once the last one has loaded.
  task automatic run_n(input int n, input bit pulse_exec);
    int  loads = 0;
    int  guard = 0;
    int  last_load_cyc = 0;
    bit  pulsed = 1'b0;
    for (int k = 0; k < n; k++) begin
      sb_q.push_back('{addr: AW'(pc_m), word: mem[pc_m], ret: ret_m});
      pc_m  = (pc_m + 1) % DEPTH;
      ret_m = ret_m + 16'd1;
    end
    last_gap = 0; last_rd_len = 0; rd_len = 0; addr_moved = 1'b0;
    start = 1'b1;
    stop  = 1'b0;
    do begin
      @(negedge clk);
      guard++;
      if (mem_rd) begin
        if (rd_len == 0) rd_addr = mem_addr;
        else if (mem_addr != rd_addr) addr_moved = 1'b1;
        rd_len++;
      end else if (rd_len != 0) begin
        last_rd_len = rd_len;
        rd_len = 0;
      end
      if (cpu_load) begin
        loads++;
        if (loads > 1) last_gap = cyc - last_load_cyc;
        last_load_cyc = cyc;
      end
      start = pulse_exec ? 1'b0 : 1'($urandom_range(0, 1));
      if (loads == n) stop = 1'b1;
      if (pulse_exec && loads == 1 && !pulsed) begin
        pulsed = 1'b1;
        repeat (3) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
      end
    end while (!(loads == n && !busy) && guard < 100 * n + 50);
    check("run_loads", 32'(loads), 32'(n));
    check("run_end_busy", 32'(busy), 32'd0);
    check("run_end_pc", 32'(pc), 32'(pc_m));
    check("run_end_retired", 32'(retired), 32'(ret_m));
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    int guard;
    bit strobe_seen;
    for (int i = 0; i < DEPTH; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15:13] == 3'b111) w[15] = 1'b0;
      mem[i] = w;
    end
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    cpu_w = 1'b1; mem_ready = 1'b0; mem_rdata = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", 32'(pc), RPC);
    check("rst_mem_addr", 32'(mem_addr), RPC);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_strobes", 32'({mem_rd, cpu_load, cpu_s}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    pc_m  = RPC;
    ret_m = 16'd0;

    // start and stop together in IDLE must not leave IDLE
    start = 1'b1; stop = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_start_stop_busy", 32'(busy), 32'd0);
    check("idle_start_stop_rd", 32'(mem_rd), 32'd0);
    start = 1'b0; stop = 1'b0;

    // Back-to-back minimum latency, across the 511 -> 0 wrap
    fixed_stall = 0; fixed_delay = 0;
    mem[pc_m] = 16'hD105;
    run_n(3, 1'b0);
    check("min_latency_gap", 32'(last_gap), 32'd6);

    // Memory stall of 5 cycles
    fixed_stall = 5;
    run_n(1, 1'b0);
    check("stall_rd_len", 32'(last_rd_len), 32'd6);
    check("stall_addr_stable", 32'(addr_moved), 32'd0);

    // stop pulse during EXEC is lost
    fixed_stall = 0; fixed_delay = 3;
    run_n(2, 1'b1);

    fixed_stall = -1; fixed_delay = -1;
    repeat (6) run_n(int'($urandom_range(1, 5)), 1'b0);

    // Reset in EXEC with the CPU still busy
    fixed_delay = 10;
    sb_q.push_back('{addr: AW'(pc_m), word: mem[pc_m], ret: ret_m});
    start = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!cpu_s && guard < 50);
    check("rst_exec_reached_start", 32'(cpu_s), 32'd1);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_exec_busy", 32'(busy), 32'd0);
    check("rst_exec_pc", 32'(pc), RPC);
    check("rst_exec_retired", 32'(retired), 32'd0);
    check("rst_exec_strobes", 32'({mem_rd, cpu_load, cpu_s}), 32'd0);
    check("rst_exec_instr", 32'(instr), 32'd0);
    pc_m  = RPC;
    ret_m = 16'd0;
    fixed_delay = -1;
    run_n(2, 1'b0);

`ifdef FETCH_SEQUENCER_HALT_EN
    mem[pc_m] = 16'hE000;
    start = 1'b1;
    guard = 0;
    strobe_seen = 1'b0;
    do begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      if (cpu_load || cpu_s) strobe_seen = 1'b1;
    end while (!halted && guard < 50);
    repeat (3) begin
      @(negedge clk);
      if (cpu_load || cpu_s) strobe_seen = 1'b1;
    end
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_busy", 32'(busy), 32'd0);
    check("halt_no_strobe", 32'(strobe_seen), 32'd0);
    check("halt_pc", 32'(pc), 32'(pc_m));
    check("halt_retired", 32'(retired), 32'(ret_m));
    check("halt_instr", 32'(instr), 32'hE000);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("halt_exit_reset", 32'(halted), 32'd0);
    check("halt_exit_pc", 32'(pc), RPC);
`else
    mem[pc_m] = 16'hE000;
    strobe_seen = 1'b0;
    run_n(1, 1'b0);
    check("no_halt_halted", 32'(halted | strobe_seen), 32'd0);
`endif

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
